// File: rtl/tri_bus_arbiter.sv
// rtl/tri_bus_arbiter.sv - round-robin arbiter for a shared tri-state bus with turnaround and tenure limit
module tri_bus_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int TURN_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         en,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy
);
    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURN_CYC + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);
    localparam logic [N-1:0]  ONE       = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    state_t        state;
    logic [IW-1:0] last;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] turn_cnt;

    logic          pick_valid;
    logic [IW-1:0] pick;
    logic          release_now;
    logic          take;
    int            idx;

    // Round-robin pick: scan from last+1 upward; the previous owner (offset N) is checked last
    always_comb begin
        pick_valid = 1'b0;
        pick       = last;
        idx        = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last) + k) % N;
            if (req[idx[IW-1:0]]) begin
                pick_valid = 1'b1;
                pick       = idx[IW-1:0];
            end
        end
    end

    // Owner gives up the bus when it stops requesting, or is forced out once its tenure is used up while others wait
    always_comb begin
        release_now = !req[owner] ||
                      ((hold_cnt == HOLD_LAST) && ((req & ~gnt) != '0));
        take        = pick_valid &&
                      ((state == IDLE) || ((state == TURN) && (turn_cnt == TURN_LAST)));
    end

    // Arbiter FSM; every output is a register so no combinational path reaches the buffer enables
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            en       <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            last     <= IW'(N - 1);
            hold_cnt <= '0;
            turn_cnt <= '0;
        end else if (take) begin
            state    <= GRANT;
            gnt      <= ONE << pick;
            en       <= ONE << pick;
            owner    <= pick;
            busy     <= 1'b1;
            last     <= pick;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                GRANT: begin
                    if (release_now) begin
                        state    <= TURN;
                        gnt      <= '0;
                        en       <= '0;
                        busy     <= 1'b0;
                        turn_cnt <= '0;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                TURN: begin
                    if (turn_cnt == TURN_LAST) begin
                        state <= IDLE;
                    end else begin
                        turn_cnt <= turn_cnt + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    en    <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tri_bus_arbiter.sv
// tb/tb_tri_bus_arbiter.sv - self-checking bench for tri_bus_arbiter against a tenure/dead-cycle model
module tb_tri_bus_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
    localparam int TURN_CYC = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic [N-1:0] en;
    logic [1:0]   owner;
    logic         busy;

    always #5 clk = ~clk;

    tri_bus_arbiter #(
        .N(N),
        .MAX_HOLD(MAX_HOLD),
        .TURN_CYC(TURN_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .gnt(gnt),
        .en(en),
        .owner(owner),
        .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] mask(input int i);
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        return one << i;
    endfunction

    function automatic int rr_pick(input int from, input logic [N-1:0] r);
        int i;
        for (int off = 1; off <= N; off++) begin
            i = (from + off) % N;
            if ((r & mask(i)) != '0) return i;
        end
        return -1;
    endfunction

    // Model: who owns the bus, how many cycles it has held it, dead cycles still to run
    int m_owner = -1;
    int m_held  = 0;
    int m_dead  = 0;
    int m_last  = N - 1;
    int m_pick;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_held  = 0;
            m_dead  = 0;
            m_last  = N - 1;
        end else if (m_owner >= 0) begin
            if ((req & mask(m_owner)) == '0 ||
                (m_held >= MAX_HOLD && (req & ~mask(m_owner)) != '0)) begin
                m_owner = -1;
                m_dead  = TURN_CYC;
            end else begin
                m_held++;
            end
        end else begin
            if (m_dead > 0) m_dead--;
            if (m_dead == 0) begin
                m_pick = rr_pick(m_last, req);
                if (m_pick >= 0) begin
                    m_owner = m_pick;
                    m_last  = m_pick;
                    m_held  = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model plus bus-safety invariants
    logic [N-1:0] prev_en = '0;
    logic [N-1:0] exp_vec;
    always @(negedge clk) begin
        exp_vec = (m_owner >= 0) ? mask(m_owner) : '0;
        check("gnt", 32'(gnt), 32'(exp_vec));
        check("en", 32'(en), 32'(exp_vec));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        if (m_owner >= 0) check("owner", 32'(owner), 32'(m_owner));
        check("en_onehot0", 32'($onehot0(en)), 32'd1);
        check("no_overlap", 32'(prev_en != '0 && en != '0 && en != prev_en), 32'd0);
        prev_en = en;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    logic [N-1:0] exp_rr;
    int           r;

    initial begin
        rst = 1'b1;
        req = '0;
        #12;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_en", 32'(en), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;

        // single requester 2
        req = 4'b0100;
        tick();
        check("t1_gnt", 32'(gnt), 32'h4);
        check("t1_en", 32'(en), 32'h4);
        check("t1_owner", 32'(owner), 32'd2);
        check("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_hold", 32'(en), 32'h4);
        end
        req = '0;
        tick();
        check("t1_turn", 32'(en), 32'h0);
        tick();
        check("t1_idle", 32'(busy), 32'd0);

        // all four requesting: 8-cycle tenures, one dead cycle between
        pulse_reset();
        req = 4'b1111;
        tick();
        for (int c = 0; c < 45; c++) begin
            exp_rr = ((c % 9) == 8) ? 4'b0000 : mask((c / 9) % 4);
            check("rr_seq", 32'(en), 32'(exp_rr));
            tick();
        end

        // sole requester is never forced out
        pulse_reset();
        req = 4'b0001;
        tick();
        for (int i = 0; i < 20; i++) begin
            check("t3_hold", 32'(gnt), 32'h1);
            tick();
        end
        req = '0;
        tick();
        check("t3_turn_en", 32'(en), 32'h0);
        check("t3_turn_busy", 32'(busy), 32'd0);
        tick();
        check("t3_idle", 32'(busy), 32'd0);

        // owner 1 drops while 3 raises
        req = 4'b0010;
        tick();
        check("t4_own1", 32'(owner), 32'd1);
        tick();
        tick();
        req = 4'b1000;
        tick();
        check("t4_dead", 32'(en), 32'h0);
        tick();
        check("t4_en3", 32'(en), 32'h8);
        check("t4_own3", 32'(owner), 32'd3);

        // async reset mid-grant
        req = 4'b0010;
        tick();
        tick();
        check("t5_pre", 32'(en), 32'h2);
        #1 rst = 1'b1;
        #0.5;
        check("t5_rst_en", 32'(en), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        #0.5 rst = 1'b0;
        req = 4'b0110;
        tick();
        check("t5_own1", 32'(owner), 32'd1);
        check("t5_en", 32'(en), 32'h2);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 15) req = req ^ mask(int'($urandom_range(0, N - 1)));
            else if (r < 18) req = N'($urandom);
            else if (r == 99) pulse_reset();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
